// File: rtl/mem_fill_arbiter_if.sv
// mem_fill_arbiter_if
//   Bundles the cache-side and memory-side signals of mem_fill_arbiter.
//   slave  : the arbiter's view (takes miss/store requests and memory read
//            data, drives fill writes, memory requests and status).
//   master : the environment's view (caches plus main memory).
//   Cache side : i_miss/i_miss_addr, d_miss/d_miss_addr, d_wr_req/addr/data,
//                d_wr_ack, busy, fill_addr/fill_data, *_fill_we, *_tag_we,
//                i_done/d_done.
//   Memory side: mem_addr, mem_enable, mem_wr, mem_data_in, mem_data_out,
//                mem_data_valid.
interface mem_fill_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              i_miss;
  logic [ADDR_W-1:0] i_miss_addr;
  logic              d_miss;
  logic [ADDR_W-1:0] d_miss_addr;
  logic              d_wr_req;
  logic [ADDR_W-1:0] d_wr_addr;
  logic [15:0]       d_wr_data;
  logic              d_wr_ack;
  logic              busy;
  logic [ADDR_W-1:0] fill_addr;
  logic [15:0]       fill_data;
  logic              i_fill_we;
  logic              d_fill_we;
  logic              i_tag_we;
  logic              d_tag_we;
  logic              i_done;
  logic              d_done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_enable;
  logic              mem_wr;
  logic [15:0]       mem_data_in;
  logic [15:0]       mem_data_out;
  logic              mem_data_valid;

  modport slave (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr,
    input  d_wr_req, d_wr_addr, d_wr_data,
    input  mem_data_out, mem_data_valid,
    output d_wr_ack, busy, fill_addr, fill_data,
    output i_fill_we, d_fill_we, i_tag_we, d_tag_we, i_done, d_done,
    output mem_addr, mem_enable, mem_wr, mem_data_in
  );

  modport master (
    output i_miss, i_miss_addr, d_miss, d_miss_addr,
    output d_wr_req, d_wr_addr, d_wr_data,
    output mem_data_out, mem_data_valid,
    input  d_wr_ack, busy, fill_addr, fill_data,
    input  i_fill_we, d_fill_we, i_tag_we, d_tag_we, i_done, d_done,
    input  mem_addr, mem_enable, mem_wr, mem_data_in
  );
endinterface

// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter
//   Shares one pipelined main memory between the I-cache and D-cache.
//   Serves line fills (D-side before I-side) and D-side write-through stores,
//   and stalls the pipeline through busy while memory is owned.
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset
//   bus  : mem_fill_arbiter_if.slave (cache requests, fill writes, memory bus)
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | memory free; pick d_miss, then i_miss, then d_wr_req
// S_FILL  | issue LINE_WORDS reads, write returned words into latched cache
// S_DONE  | one cycle: pulse *_done for the latched side
// S_WRITE | one cycle: issue the write-through store, pulse d_wr_ack
module mem_fill_arbiter #(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  mem_fill_arbiter_if.slave  bus
);

  localparam int CW = $clog2(LINE_WORDS);
  localparam logic [CW:0]       IC_END   = (CW+1)'(LINE_WORDS);
  localparam logic [CW-1:0]     RC_LAST  = CW'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(2*LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DONE  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              side_d_q, side_d_d;   // 1 = D-cache fill, 0 = I-cache fill
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CW:0]       ic_q, ic_d;           // read issue counter, stops at LINE_WORDS
  logic [CW-1:0]     rc_q, rc_d;           // receive counter

  logic [ADDR_W-1:0] issue_off;
  logic [ADDR_W-1:0] recv_off;
  logic              req_pending;

  // Base is line aligned, so OR-ing the word offset can never carry out of
  // the line; a miss in the last line of memory stays inside it.
  assign issue_off   = ADDR_W'({ic_q[CW-1:0], 1'b0});
  assign recv_off    = ADDR_W'({rc_q, 1'b0});
  assign req_pending = bus.d_miss | bus.i_miss | bus.d_wr_req;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      side_d_q <= 1'b0;
      base_q   <= '0;
      ic_q     <= '0;
      rc_q     <= '0;
    end else begin
      state_q  <= state_d;
      side_d_q <= side_d_d;
      base_q   <= base_d;
      ic_q     <= ic_d;
      rc_q     <= rc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    side_d_d = side_d_q;
    base_d   = base_q;
    ic_d     = ic_q;
    rc_d     = rc_q;
    unique case (state_q)
      S_IDLE: begin
        ic_d = '0;
        rc_d = '0;
        if (bus.d_miss) begin
          state_d  = S_FILL;
          side_d_d = 1'b1;
          base_d   = bus.d_miss_addr & ~OFF_MASK;
        end else if (bus.i_miss) begin
          state_d  = S_FILL;
          side_d_d = 1'b0;
          base_d   = bus.i_miss_addr & ~OFF_MASK;
        end else if (bus.d_wr_req) begin
          state_d = S_WRITE;
        end
      end
      S_FILL: begin
        if (ic_q != IC_END) begin
          ic_d = ic_q + 1'b1;
        end
        // Completion follows returned data, so any memory latency works.
        if (bus.mem_data_valid) begin
          rc_d = rc_q + 1'b1;
          if (rc_q == RC_LAST) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.d_wr_ack    = 1'b0;
    bus.fill_addr   = '0;
    bus.fill_data   = '0;
    bus.i_fill_we   = 1'b0;
    bus.d_fill_we   = 1'b0;
    bus.i_tag_we    = 1'b0;
    bus.d_tag_we    = 1'b0;
    bus.i_done      = 1'b0;
    bus.d_done      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_enable  = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_data_in = '0;
    // Gated by rst so every output reads 0 while reset is held, even with
    // requests still asserted.
    bus.busy        = rst & ((state_q != S_IDLE) | req_pending);
    unique case (state_q)
      S_IDLE: ;
      S_FILL: begin
        bus.fill_addr = base_q | recv_off;
        if (ic_q != IC_END) begin
          bus.mem_enable = 1'b1;
          bus.mem_addr   = base_q | issue_off;
        end
        if (bus.mem_data_valid) begin
          bus.fill_data = bus.mem_data_out;
          bus.d_fill_we = side_d_q;
          bus.i_fill_we = ~side_d_q;
          if (rc_q == RC_LAST) begin
            bus.d_tag_we = side_d_q;
            bus.i_tag_we = ~side_d_q;
          end
        end
      end
      S_DONE: begin
        bus.d_done = side_d_q;
        bus.i_done = ~side_d_q;
      end
      S_WRITE: begin
        bus.mem_enable  = 1'b1;
        bus.mem_wr      = 1'b1;
        bus.mem_addr    = bus.d_wr_addr;
        bus.mem_data_in = bus.d_wr_data;
        bus.d_wr_ack    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter with a latency-4 memory model.
module tb_mem_fill_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_fill_arbiter_if #(.ADDR_W(16)) bus ();

  mem_fill_arbiter #(.LINE_WORDS(8), .ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory read pipeline: stage 3 is presented 4 cycles after issue
  logic        vp [4];
  logic [15:0] ap [4];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; returns 1ns after the rising edge with memory
  // return data for the new cycle already driven.
  task automatic cyc();
    logic        iss;
    logic [15:0] iss_a;
    @(negedge clk);
    iss   = bus.mem_enable & ~bus.mem_wr;
    iss_a = bus.mem_addr;
    @(posedge clk);
    #1;
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        vp[i] = 1'b0;
        ap[i] = '0;
      end
    end else begin
      for (int i = 3; i > 0; i--) begin
        vp[i] = vp[i-1];
        ap[i] = ap[i-1];
      end
      vp[0] = iss;
      ap[0] = iss_a;
    end
    bus.mem_data_valid = vp[3];
    bus.mem_data_out   = vp[3] ? mem_word(ap[3]) : 16'h0000;
  endtask

  // Called in the cycle the miss is first visible (cycle 0); returns in
  // cycle 14 with the miss dropped, at 1ns after the edge.
  task automatic run_fill(input bit side_d, input logic [15:0] base, input bit chg_addr);
    logic en_e, we_e;
    #1;
    chk("c0_busy", bus.busy, 1'b1);
    chk("c0_mem_en", bus.mem_enable, 1'b0);
    for (int k = 1; k <= 13; k++) begin
      cyc();
      if (chg_addr && k == 3) bus.d_miss_addr = 16'h7776;
      #1;
      en_e = (k <= 8);
      we_e = (k >= 5 && k <= 12);
      chk("mem_en", bus.mem_enable, en_e);
      if (en_e) begin
        chk("mem_addr", bus.mem_addr, base + 16'(2*(k-1)));
        chk("mem_wr", bus.mem_wr, 1'b0);
      end
      chk("d_fill_we", bus.d_fill_we, side_d & we_e);
      chk("i_fill_we", bus.i_fill_we, ~side_d & we_e);
      if (we_e) begin
        chk("fill_addr", bus.fill_addr, base + 16'(2*(k-5)));
        chk("fill_data", bus.fill_data, mem_word(base + 16'(2*(k-5))));
      end
      chk("d_tag_we", bus.d_tag_we, side_d && k == 12);
      chk("i_tag_we", bus.i_tag_we, !side_d && k == 12);
      chk("d_done", bus.d_done, side_d && k == 13);
      chk("i_done", bus.i_done, !side_d && k == 13);
      chk("fill_busy", bus.busy, 1'b1);
    end
    cyc();
    if (side_d) bus.d_miss = 1'b0;
    else        bus.i_miss = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 4; i++) begin
      vp[i] = 1'b0;
      ap[i] = '0;
    end
    rst                = 1'b0;
    bus.i_miss         = 1'b1;
    bus.i_miss_addr    = 16'h0000;
    bus.d_miss         = 1'b1;
    bus.d_miss_addr    = 16'h0000;
    bus.d_wr_req       = 1'b1;
    bus.d_wr_addr      = 16'h0000;
    bus.d_wr_data      = 16'h0000;
    bus.mem_data_out   = 16'h0000;
    bus.mem_data_valid = 1'b0;

    // reset with requests held: everything stays 0
    cyc();
    cyc();
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_mem_en", bus.mem_enable, 1'b0);
    chk("rst_ack", bus.d_wr_ack, 1'b0);
    chk("rst_dfill", bus.d_fill_we, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 16'h0000);
    bus.i_miss   = 1'b0;
    bus.d_miss   = 1'b0;
    bus.d_wr_req = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    #1;
    chk("idle_busy", bus.busy, 1'b0);

    // 1: lone D miss
    cyc();
    bus.d_miss      = 1'b1;
    bus.d_miss_addr = 16'h1236;
    run_fill(1'b1, 16'h1230, 1'b0);
    #1;
    chk("t1_idle_busy", bus.busy, 1'b0);
    chk("t1_idle_en", bus.mem_enable, 1'b0);

    // 2: simultaneous I and D miss, D first
    cyc();
    bus.i_miss      = 1'b1;
    bus.i_miss_addr = 16'h0040;
    bus.d_miss      = 1'b1;
    bus.d_miss_addr = 16'h2008;
    run_fill(1'b1, 16'h2000, 1'b0);
    run_fill(1'b0, 16'h0040, 1'b0);
    #1;
    chk("t2_idle_busy", bus.busy, 1'b0);

    // 3: write-through store
    cyc();
    bus.d_wr_req  = 1'b1;
    bus.d_wr_addr = 16'h3002;
    bus.d_wr_data = 16'hBEEF;
    #1;
    chk("wr_c0_busy", bus.busy, 1'b1);
    chk("wr_c0_en", bus.mem_enable, 1'b0);
    cyc();
    #1;
    chk("wr_en", bus.mem_enable, 1'b1);
    chk("wr_wr", bus.mem_wr, 1'b1);
    chk("wr_addr", bus.mem_addr, 16'h3002);
    chk("wr_data", bus.mem_data_in, 16'hBEEF);
    chk("wr_ack", bus.d_wr_ack, 1'b1);
    chk("wr_busy", bus.busy, 1'b1);
    bus.d_wr_req = 1'b0;
    cyc();
    #1;
    chk("wr_after_ack", bus.d_wr_ack, 1'b0);
    chk("wr_after_en", bus.mem_enable, 1'b0);
    chk("wr_after_busy", bus.busy, 1'b0);

    // d_miss together with d_wr_req: fill, then store
    cyc();
    bus.d_miss      = 1'b1;
    bus.d_miss_addr = 16'h5006;
    bus.d_wr_req    = 1'b1;
    bus.d_wr_addr   = 16'h6000;
    bus.d_wr_data   = 16'h1111;
    run_fill(1'b1, 16'h5000, 1'b0);
    #1;
    chk("fs_busy", bus.busy, 1'b1);
    chk("fs_idle_en", bus.mem_enable, 1'b0);
    cyc();
    #1;
    chk("fs_wr", bus.mem_wr, 1'b1);
    chk("fs_addr", bus.mem_addr, 16'h6000);
    chk("fs_ack", bus.d_wr_ack, 1'b1);
    bus.d_wr_req = 1'b0;
    cyc();

    // 4: reset after third fill word, then refill
    cyc();
    bus.d_miss      = 1'b1;
    bus.d_miss_addr = 16'h4010;
    for (int k = 1; k <= 7; k++) cyc();
    #1;
    chk("r4_w3_we", bus.d_fill_we, 1'b1);
    chk("r4_w3_addr", bus.fill_addr, 16'h4014);
    cyc();
    rst = 1'b0;
    #1;
    chk("r4_busy", bus.busy, 1'b0);
    chk("r4_en", bus.mem_enable, 1'b0);
    chk("r4_we", bus.d_fill_we, 1'b0);
    chk("r4_tag", bus.d_tag_we, 1'b0);
    chk("r4_faddr", bus.fill_addr, 16'h0000);
    chk("r4_fdata", bus.fill_data, 16'h0000);
    chk("r4_maddr", bus.mem_addr, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1;
      chk("r4_hold_tag", bus.d_tag_we, 1'b0);
      chk("r4_hold_done", bus.d_done, 1'b0);
    end
    cyc();
    rst = 1'b1;
    run_fill(1'b1, 16'h4010, 1'b0);

    // 5: last line of memory
    cyc();
    bus.i_miss      = 1'b1;
    bus.i_miss_addr = 16'hFFFE;
    run_fill(1'b0, 16'hFFF0, 1'b0);

    // 6: stray valid in IDLE, then address change mid-fill
    cyc();
    bus.mem_data_valid = 1'b1;
    bus.mem_data_out   = 16'h1234;
    #1;
    chk("stray_dwe", bus.d_fill_we, 1'b0);
    chk("stray_iwe", bus.i_fill_we, 1'b0);
    chk("stray_tag", bus.d_tag_we | bus.i_tag_we, 1'b0);
    chk("stray_data", bus.fill_data, 16'h0000);
    chk("stray_busy", bus.busy, 1'b0);
    cyc();
    bus.d_miss      = 1'b1;
    bus.d_miss_addr = 16'h0A1C;
    run_fill(1'b1, 16'h0A10, 1'b1);
    cyc();
    #1;
    chk("end_busy", bus.busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
